// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: request/response bundle between the pipeline stages and the stall/flush sequencer
// slave  : the sequencer (takes requests, drives stall/flush/divider control/counter)
// master : the pipeline side (drives requests, consumes stall/flush/divider control/counter)
interface pipeline_ctrl_if #(parameter int CNT_W = 32);
   logic             stallreq_id_i;
   logic             div_start_i;
   logic             div_ready_i;
   logic             mem_req_i;
   logic             mem_ack_i;
   logic             flush_req_i;
   logic [31:0]      flush_pc_in_i;
   logic             stall_cnt_clr_i;
   logic [5:0]       stall_o;
   logic             flush_o;
   logic [31:0]      new_pc_o;
   logic             div_cancel_o;
   logic             div_busy_o;
   logic             div_timeout_o;
   logic [CNT_W-1:0] stall_cycles_o;
   modport slave (
      input  stallreq_id_i, div_start_i, div_ready_i, mem_req_i, mem_ack_i,
             flush_req_i, flush_pc_in_i, stall_cnt_clr_i,
      output stall_o, flush_o, new_pc_o, div_cancel_o, div_busy_o, div_timeout_o,
             stall_cycles_o
   );
   modport master (
      output stallreq_id_i, div_start_i, div_ready_i, mem_req_i, mem_ack_i,
             flush_req_i, flush_pc_in_i, stall_cnt_clr_i,
      input  stall_o, flush_o, new_pc_o, div_cancel_o, div_busy_o, div_timeout_o,
             stall_cycles_o
   );
endinterface

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for the 5-stage pipeline with divider timeout and stall-cycle counter
// clk   : rising-edge clock
// rst_n : asynchronous active-low reset
// bus   : pipeline_ctrl_if.slave -- stall requests (ID/EX divider/MEM bus), flush request + PC,
//         counter clear in; stall[5:0] (combinational), flush/new_pc, div_cancel/div_busy/div_timeout,
//         stall_cycles out (registered)
module pipeline_ctrl #(
   parameter int DIV_TIMEOUT = 64,
   parameter int CNT_W       = 32
) (
   input logic             clk,
   input logic             rst_n,
   pipeline_ctrl_if.slave  bus
);
   localparam int TW = $clog2(DIV_TIMEOUT) + 1;
   localparam logic [1:0] RUN      = 2'd0;
   localparam logic [1:0] DIV_WAIT = 2'd1;
   localparam logic [1:0] MEM_WAIT = 2'd2;
   localparam logic [1:0] FLUSH    = 2'd3;
   localparam logic [5:0] ST_ID  = 6'b000111;
   localparam logic [5:0] ST_EX  = 6'b001111;
   localparam logic [5:0] ST_MEM = 6'b011111;
   logic [1:0]       state_q, state_d;
   logic [TW-1:0]    tcnt_q, tcnt_d;
   logic             pend_q, pend_d;
   logic             flush_q;
   logic             busy_q;
   logic [31:0]      pc_q, pc_d;
   logic             cancel_q, cancel_d;
   logic             to_q, to_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [5:0]       stall;
   always_comb begin
      state_d  = state_q;
      tcnt_d   = tcnt_q;
      pend_d   = 1'b0;
      pc_d     = pc_q;
      cancel_d = 1'b0;
      to_d     = to_q;
      stall    = '0;
      case (state_q)
         RUN: begin
            if (bus.flush_req_i) begin
               state_d = FLUSH;
               pc_d    = bus.flush_pc_in_i;
            end else if (bus.mem_req_i && !bus.mem_ack_i) begin
               stall   = ST_MEM;
               state_d = MEM_WAIT;
            end else if (bus.div_start_i) begin
               stall   = ST_EX;
               state_d = DIV_WAIT;
               tcnt_d  = '0;
            end else if (bus.stallreq_id_i) begin
               stall   = ST_ID;
            end
         end
         DIV_WAIT: begin
            tcnt_d = tcnt_q + TW'(1);
            if (bus.flush_req_i) begin
               cancel_d = 1'b1;
               pc_d     = bus.flush_pc_in_i;
               state_d  = FLUSH;
            end else if (bus.div_ready_i) begin
               state_d  = RUN;
            end else if (tcnt_q == TW'(DIV_TIMEOUT - 1)) begin
               to_d     = 1'b1;
               cancel_d = 1'b1;
               state_d  = RUN;
            end else begin
               stall    = ST_EX;
            end
         end
         MEM_WAIT: begin
            // a flush arriving on the ack cycle itself still counts as pending
            pc_d    = bus.flush_req_i ? bus.flush_pc_in_i : pc_q;
            pend_d  = !bus.mem_ack_i && (pend_q || bus.flush_req_i);
            stall   = bus.mem_ack_i ? '0 : ST_MEM;
            state_d = !bus.mem_ack_i ? MEM_WAIT : (pend_q || bus.flush_req_i) ? FLUSH : RUN;
         end
         default: begin
            pc_d    = bus.flush_req_i ? bus.flush_pc_in_i : pc_q;
            state_d = bus.flush_req_i ? FLUSH : RUN;
         end
      endcase
      cnt_d = bus.stall_cnt_clr_i ? '0 : (|stall && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= RUN;
         tcnt_q   <= '0;
         pend_q   <= 1'b0;
         flush_q  <= 1'b0;
         busy_q   <= 1'b0;
         pc_q     <= '0;
         cancel_q <= 1'b0;
         to_q     <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         tcnt_q   <= tcnt_d;
         pend_q   <= pend_d;
         flush_q  <= state_d == FLUSH;
         busy_q   <= state_d == DIV_WAIT;
         pc_q     <= pc_d;
         cancel_q <= cancel_d;
         to_q     <= to_d;
         cnt_q    <= cnt_d;
      end
   end
   assign bus.stall_o        = stall;
   assign bus.flush_o        = flush_q;
   assign bus.new_pc_o       = pc_q;
   assign bus.div_cancel_o   = cancel_q;
   assign bus.div_busy_o     = busy_q;
   assign bus.div_timeout_o  = to_q;
   assign bus.stall_cycles_o = cnt_q;
endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline; drives the shared stall[5:0] vector consumed by the pc, if_id, id_ex, ex_mem and mem_wb pipeline registers.
- Arbitrates between stall sources: ID load-use hazards, the EX multi-cycle divider and the MEM bus wait.
- Sequences exception/branch flushes with a redirect PC.
- Keeps a saturating stall-cycle performance counter.

Parameters:
- DIV_TIMEOUT, 64: maximum cycles spent in DIV_WAIT before the divide is abandoned.
- CNT_W, 32: width of stall_cycles.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous active-low reset
- stallreq_id  in  1  ID hazard stall request, level
- div_start  in  1  EX issues a divide, one-cycle pulse
- div_ready  in  1  divider result valid, one-cycle pulse
- mem_req  in  1  MEM stage bus access pending, level
- mem_ack  in  1  bus completes the access this cycle
- flush_req  in  1  exception/redirect request, one-cycle pulse
- flush_pc_in  in  32  redirect target accompanying flush_req
- stall_cnt_clr  in  1  synchronous clear of stall_cycles
- stall  out  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB
- flush  out  1  pipeline flush, one cycle
- new_pc  out  32  redirect PC, valid while flush=1
- div_cancel  out  1  abort the divider, one-cycle pulse
- div_busy  out  1  high while state is DIV_WAIT
- div_timeout  out  1  sticky, set when a divide times out
- stall_cycles  out  CNT_W  count of cycles with stall != 0

Behaviour:
- Reset (rst=0, asynchronous):
  - state=RUN.
  - All outputs 0, including new_pc, stall_cycles and div_timeout.
  - Timeout counter and flush_pending cleared.
- Stall patterns: ID=6'b000111, EX=6'b001111, MEM=6'b011111, none=0.
  - The EX pattern makes ex_mem inject a bubble into MEM (stall[3]=1, stall[4]=0).
- stall is combinational from the current state and the inputs. All other outputs are registered.
- State RUN:
  - Priority: flush_req > (mem_req & !mem_ack) > div_start > stallreq_id.
  - flush_req: next state FLUSH; latch flush_pc_in into new_pc; stall=0 this cycle.
  - mem_req & !mem_ack: stall=MEM; next state MEM_WAIT.
  - div_start: stall=EX; next state DIV_WAIT; timeout counter cleared to 0.
  - stallreq_id only: stall=ID; stay in RUN.
  - No request: stall=0.
- State DIV_WAIT:
  - stall=EX each cycle until exit; div_busy=1; timeout counter increments every cycle.
  - div_ready: stall=0 that cycle; next state RUN.
  - flush_req (takes priority over div_ready): stall=0; pulse div_cancel next cycle; latch new_pc; next state FLUSH.
  - Counter reaches DIV_TIMEOUT-1 without div_ready:
    - set div_timeout and pulse div_cancel next cycle;
    - stall=0; next state RUN;
    - div_timeout stays set until reset.
  - stallreq_id is ignored, because the EX stall covers ID.
- State MEM_WAIT:
  - stall=MEM until mem_ack; on the mem_ack cycle stall=0.
  - Not interruptible by flush. A flush_req arriving here is latched (flush_pending, new_pc captured); later requests overwrite the latched PC.
  - On mem_ack: next state FLUSH if flush_pending, else RUN.
  - mem_req dropping without mem_ack is illegal; the block stays in MEM_WAIT.
- State FLUSH:
  - Exactly one cycle: flush=1, stall=0, new_pc holds the latched PC.
  - flush_pending is cleared; next state RUN.
  - A flush_req arriving in FLUSH re-enters FLUSH with the new PC.
- flush and new_pc are registered:
  - flush rises on the cycle after flush_req is sampled in RUN or DIV_WAIT.
  - new_pc holds its value after the flush cycle.
- stall_cycles:
  - +1 on every cycle where stall != 0.
  - Saturates at all-ones.
  - stall_cnt_clr forces 0 and wins over increment.
- Reset asserted mid-operation abandons any wait immediately. No div_cancel is pulsed.

Test Plan:
- Reset release, no requests, 10 cycles -> stall=0, flush=0, stall_cycles=0.
- stallreq_id high 3 cycles -> stall=6'b000111 for exactly 3 cycles; stall_cycles=3.
- div_start, div_ready 5 cycles later -> stall=6'b001111 for 5 cycles, div_busy=1, then stall=0 on the div_ready cycle; state back to RUN.
- div_start with no div_ready, DIV_TIMEOUT=8 -> div_timeout=1 after 8 cycles, div_cancel one-cycle pulse, stall=0; div_timeout still 1 100 cycles later.
- mem_req with mem_ack after 4 cycles, flush_req (pc 0x0000_0120) during the wait:
  - stall=6'b011111 until ack, then one cycle with flush=1, new_pc=0x120.
  - flush during DIV_WAIT -> div_cancel pulse and flush=1 with the latched PC.
- Counter saturation, CNT_W=4, 20 stalled cycles -> stall_cycles=4'hF; stall_cnt_clr together with a stall -> 0.
